// File: rtl/pipe_stall_flush_ctrl.sv
// Central pipeline stall/flush controller: per-stage stall requests, internally
// timed multi-cycle EX waits, registered flush/redirect, stall accounting and hang watchdog.
module pipe_stall_flush_ctrl #(
    parameter int STAGES  = 6,
    parameter int EX_IDX  = 3,
    parameter int PC_W    = 32,
    parameter int MC_W    = 6,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              mc_start,
    input  logic [MC_W-1:0]   mc_cycles,
    input  logic              mc_done,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc_in,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   flush_pc,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              hang_err
);

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    localparam int HC_W = $clog2(TIMEOUT + 1);
    localparam logic [HC_W-1:0] HC_MAX  = HC_W'(TIMEOUT);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(TIMEOUT - 1);

    state_t            state;
    logic [MC_W-1:0]   cnt;
    logic [HC_W-1:0]   hcnt;
    logic [STAGES-1:0] eff_req;
    logic [STAGES-1:0] stall_chain;
    logic              acc;

    // A request from stage s holds every older stage as well, so fold from the WB end down.
    always_comb begin
        eff_req = stall_req;
        if (state == MC_WAIT) eff_req[EX_IDX] = 1'b1;
        acc         = 1'b0;
        stall_chain = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc            = acc | eff_req[k];
            stall_chain[k] = acc;
        end
    end

    assign stall = (rst || state == FLUSH) ? '0 : stall_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            hcnt         <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
            mc_busy      <= 1'b0;
            stall_cycles <= '0;
            hang_err     <= 1'b0;
        end else begin
            if (stall[0]) begin
                if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
                if (hcnt != HC_MAX)     hcnt <= hcnt + 1'b1;
                if (hcnt == HC_LAST)    hang_err <= 1'b1;
            end else begin
                hcnt <= '0;
            end

            flush <= 1'b0;
            // A redirect beats everything, including an in-flight multi-cycle wait.
            if (flush_req) begin
                state    <= FLUSH;
                flush    <= 1'b1;
                flush_pc <= flush_pc_in;
                mc_busy  <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (mc_start && mc_cycles != '0) begin
                            state   <= MC_WAIT;
                            cnt     <= mc_cycles;
                            mc_busy <= 1'b1;
                        end
                    end
                    MC_WAIT: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == MC_W'(1) || mc_done) begin
                            state   <= RUN;
                            mc_busy <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        state <= RUN;
                    end
                    default: begin
                        state   <= RUN;
                        mc_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
